mdu_iter: RTL and testbench
===========================

# mdu_iter

Parametrised multi-cycle multiply/divide unit for the EXE stage. It replaces the fixed 32-bit vendor divider IP and the single-cycle combinational multiplier with one self-contained engine. The engine has a valid/ready operand handshake, a held result port, pipeline flush, and deterministic divide-by-zero results. The EXE stage issues MULT/MULTU/DIV/DIVU here, stalls on `busy`, and writes `out_hi`/`out_lo` into HI/LO on the result handshake.

## Interface
Parameters:
- `XLEN`, 32: operand width. Even, at least 8.
- `MUL_LAT`, 2: multiply latency in cycles, from the accept cycle to the first `out_valid` cycle. At least 1.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  operation request.
- `in_ready`  out  1  unit can accept an operation.
- `in_op`  in  2  operation code: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU.
- `in_src1`  in  XLEN  multiplicand or dividend.
- `in_src2`  in  XLEN  multiplier or divisor.
- `flush`  in  1  cancels any in-flight or held operation.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_hi`  out  XLEN  product high half, or remainder.
- `out_lo`  out  XLEN  product low half, or quotient.
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, MUL, DIV, FIX, DONE.
- An operation is accepted when `in_valid & in_ready` and `flush` is low. `in_ready` = (state == IDLE).
- On accept, operands and op are registered. The divide path stores the operand magnitudes, plus the quotient sign (operand signs differ) and the remainder sign (dividend sign). Signed ops only.
- MUL state:
  - The 2·XLEN product is computed from the registered operands, sign-extended for MULT and zero-extended for MULTU.
  - A counter runs MUL_LAT−1 cycles, then the state goes to DONE. When MUL_LAT=1, the state goes from IDLE directly to DONE.
- DIV state:
  - Radix-2 restoring division on the magnitudes, one quotient bit per cycle, for exactly XLEN cycles. Counter runs XLEN−1 down to 0.
  - Then the state goes to FIX.
- FIX state: apply the stored signs (two's-complement negate where required), then go to DONE.
- DONE state: `out_valid`=1, and `out_hi`/`out_lo` hold stable. On `out_ready`, the state goes to IDLE.
- Divide by zero (divisor == 0): `out_lo` = all ones, `out_hi` = `in_src1` unchanged, for both DIV and DIVU.
- Signed overflow (DIV, most-negative value / −1): `out_lo` = most-negative value, `out_hi` = 0.
- Quotient truncates toward zero. The remainder takes the dividend's sign.
- `flush`:
  - Synchronous, takes effect in every state. The next state is IDLE and `out_valid` is 0 next cycle.
  - Partial results are discarded.
  - `flush` together with `in_valid` in IDLE: flush wins and the op is not accepted.
- `reset` mid-operation: identical to `flush`; all internal registers are cleared.
- Reset values: `in_ready`=1, `busy`=0, `out_valid`=0, `out_hi`=0, `out_lo`=0.

## Timing
- Accept cycle = cycle 0.
- Multiply: `out_valid` first high in cycle MUL_LAT.
- Divide: `out_valid` first high in cycle XLEN+2 (34 for XLEN=32).
- Under backpressure (`out_ready` low), the result holds indefinitely. Back-to-back issue is possible one cycle after the result handshake.
- All outputs are registered. No combinational path from any input to any output except `in_ready` (state only).

## Configuration
- Macro `MDU_DIV_EARLY_OUT_EN`.
- Defined: in the accept cycle, if divisor == 0 or |dividend| < |divisor|, DIV is skipped and the state goes directly to FIX. Divide latency is then 2. Results are identical to the full path: q=0 and r=dividend, or the divide-by-zero values.
- Undefined: every divide takes XLEN+2 cycles and there is no magnitude comparator.

## Structure
- Shared package `mdu_pkg`:
  - op encoding constants `MDU_MULT`, `MDU_MULTU`, `MDU_DIV`, `MDU_DIVU`;
  - state enum type `mdu_state_t`.
- Sub-module `mdu_div_step`: one combinational restoring-division step (partial remainder and divisor in; next remainder and quotient bit out), XLEN-parametrised.
- The FSM, counters, sign fix-up and multiplier stay in `mdu_iter`.

## Test plan
XLEN=32, MUL_LAT=2:
- MULT 0xFFFFFFFF × 0x00000002 → hi=0xFFFFFFFF, lo=0xFFFFFFFE, `out_valid` in cycle 2. MULTU with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIV −7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF, `out_valid` in cycle 34. DIVU 100 / 7 → lo=14, hi=2.
- DIVU 0x80000000 / 0 → lo=0xFFFFFFFF, hi=0x80000000. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. With `MDU_DIV_EARLY_OUT_EN`, DIVU 3 / 9 → lo=0, hi=3 in cycle 2.
- `flush` in cycle 10 of a DIV → `out_valid` never rises, `in_ready`=1 in cycle 11. A following DIVU 100 / 7 completes correctly.
- Hold `out_ready`=0 for 20 cycles after a MULT result → `out_valid` and data stable, `in_ready`=0 throughout. `out_ready`=1 → `in_ready`=1 next cycle.
- `reset` asserted during MUL → all outputs at reset values next cycle. `in_valid`+`flush` in the same IDLE cycle → no accept, `busy` stays 0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: operation
// encodings and the controller state type.
package mdu_pkg;

  localparam logic [1:0] MDU_MULT  = 2'd0;
  localparam logic [1:0] MDU_MULTU = 2'd1;
  localparam logic [1:0] MDU_DIV   = 2'd2;
  localparam logic [1:0] MDU_DIVU  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } mdu_state_t;

endpackage

// File: rtl/mdu_div_step.sv
// One radix-2 restoring-division step. The next dividend bit is shifted into
// the partial remainder, the divisor is trial-subtracted, and the subtraction
// is kept only when it does not go negative.
module mdu_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_in,
  input  logic            dvd_bit,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_out,
  output logic            q_bit
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] trial;

  // Trial subtraction; the extra top bit is the borrow and decides the quotient bit.
  always_comb begin
    shifted = {rem_in, dvd_bit};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[XLEN];
    rem_out = q_bit ? trial[XLEN-1:0] : shifted[XLEN-1:0];
  end

endmodule

// File: rtl/mdu_iter.sv
// Multi-cycle multiply/divide engine for the EXE stage.
// MULT/MULTU finish after MUL_LAT cycles; DIV/DIVU run a restoring divider
// for XLEN cycles followed by one sign fix-up cycle. The result is held
// until the consumer takes it. Optional build macro MDU_DIV_EARLY_OUT_EN
// skips the iteration when the divisor is zero or |dividend| < |divisor|.
module mdu_iter #(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_src1,
  input  logic [XLEN-1:0] in_src2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_hi,
  output logic [XLEN-1:0] out_lo,
  output logic            busy
);

  import mdu_pkg::*;

  localparam int CNT_MAX  = (XLEN > MUL_LAT) ? XLEN : MUL_LAT;
  localparam int CNT_W    = $clog2(CNT_MAX);
  // The MUL state lasts MUL_LAT-1 cycles; the counter ends at zero.
  localparam int MUL_LOAD = (MUL_LAT >= 2) ? MUL_LAT - 2 : 0;

  mdu_state_t state, state_nxt;

  logic            accept;
  logic            is_div_in;
  logic            div_signed_in;
  logic [XLEN-1:0] dvd_mag_in;
  logic [XLEN-1:0] dvs_mag_in;
  logic            early_out;

  logic [XLEN-1:0] src1_q;
  logic [XLEN-1:0] src2_q;
  logic [XLEN-1:0] dvs_mag_q;
  logic            mul_signed_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic            div_zero_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] res_hi_q;
  logic [XLEN-1:0] res_lo_q;

  logic [XLEN-1:0]   mul_a;
  logic [XLEN-1:0]   mul_b;
  logic              mul_sgn;
  logic [2*XLEN-1:0] product;

  logic [XLEN-1:0] step_rem;
  logic            step_q;

  // Decode the incoming request: accept condition and divide operand magnitudes.
  always_comb begin
    accept        = in_valid & (state == S_IDLE) & ~flush;
    is_div_in     = (in_op == MDU_DIV) || (in_op == MDU_DIVU);
    div_signed_in = (in_op == MDU_DIV);
    dvd_mag_in    = (div_signed_in & in_src1[XLEN-1]) ? -in_src1 : in_src1;
    dvs_mag_in    = (div_signed_in & in_src2[XLEN-1]) ? -in_src2 : in_src2;
`ifdef MDU_DIV_EARLY_OUT_EN
    early_out     = (in_src2 == '0) || (dvd_mag_in < dvs_mag_in);
`else
    early_out     = 1'b0;
`endif
  end

  // Full-width product; with single-cycle latency it is taken straight from the request.
  always_comb begin
    if (MUL_LAT == 1) begin
      mul_a   = in_src1;
      mul_b   = in_src2;
      mul_sgn = (in_op == MDU_MULT);
    end else begin
      mul_a   = src1_q;
      mul_b   = src2_q;
      mul_sgn = mul_signed_q;
    end
    product = {{XLEN{mul_sgn & mul_a[XLEN-1]}}, mul_a}
            * {{XLEN{mul_sgn & mul_b[XLEN-1]}}, mul_b};
  end

  mdu_div_step #(.XLEN(XLEN)) u_div_step (
    .rem_in  (rem_q),
    .dvd_bit (quo_q[XLEN-1]),
    .divisor (dvs_mag_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (is_div_in)         state_nxt = early_out ? S_FIX : S_DIV;
          else if (MUL_LAT == 1) state_nxt = S_DONE;
          else                   state_nxt = S_MUL;
        end
      end
      S_MUL:   if (cnt_q == '0) state_nxt = S_DONE;
      S_DIV:   if (cnt_q == '0) state_nxt = S_FIX;
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  if (out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

  // Handshake outputs are pure decodes of the state register.
  always_comb begin
    in_ready  = (state == S_IDLE);
    busy      = (state != S_IDLE);
    out_valid = (state == S_DONE);
  end

  assign out_hi = res_hi_q;
  assign out_lo = res_lo_q;

  // Operand capture, iteration, sign fix-up and result holding.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath is reset too because out_hi/out_lo have defined reset values.
      src1_q       <= '0;
      src2_q       <= '0;
      dvs_mag_q    <= '0;
      mul_signed_q <= 1'b0;
      q_neg_q      <= 1'b0;
      r_neg_q      <= 1'b0;
      div_zero_q   <= 1'b0;
      cnt_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      res_hi_q     <= '0;
      res_lo_q     <= '0;
    end else if (!flush) begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            src1_q       <= in_src1;
            src2_q       <= in_src2;
            dvs_mag_q    <= dvs_mag_in;
            mul_signed_q <= (in_op == MDU_MULT);
            q_neg_q      <= div_signed_in & (in_src1[XLEN-1] ^ in_src2[XLEN-1]);
            r_neg_q      <= div_signed_in & in_src1[XLEN-1];
            div_zero_q   <= (in_src2 == '0);
            if (is_div_in) begin
              cnt_q <= CNT_W'(XLEN - 1);
              if (early_out) begin
                // Quotient is zero and the remainder is the whole dividend.
                quo_q <= '0;
                rem_q <= dvd_mag_in;
              end else begin
                // quo_q starts as the dividend and is shifted out as quotient bits enter.
                quo_q <= dvd_mag_in;
                rem_q <= '0;
              end
            end else begin
              cnt_q <= CNT_W'(MUL_LOAD);
              if (MUL_LAT == 1) {res_hi_q, res_lo_q} <= product;
            end
          end
        end
        S_MUL: begin
          if (cnt_q == '0) {res_hi_q, res_lo_q} <= product;
          else             cnt_q <= cnt_q - 1'b1;
        end
        S_DIV: begin
          rem_q <= step_rem;
          quo_q <= {quo_q[XLEN-2:0], step_q};
          cnt_q <= cnt_q - 1'b1;
        end
        S_FIX: begin
          if (div_zero_q) begin
            res_lo_q <= '1;
            res_hi_q <= src1_q;
          end else begin
            // Most-negative / -1 lands here naturally: negating 2^(XLEN-1) wraps to itself.
            res_lo_q <= q_neg_q ? -quo_q : quo_q;
            res_hi_q <= r_neg_q ? -rem_q : rem_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter (XLEN=32, MUL_LAT=2). A transaction-level
// model (accept -> fixed latency -> held result -> handshake) predicts the
// handshake outputs and result data every cycle; results come from plain
// 64-bit arithmetic. Honours MDU_DIV_EARLY_OUT_EN when the design is built with it.
module tb_mdu_iter;

  import mdu_pkg::*;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mdu_iter #(.XLEN(XLEN), .MUL_LAT(MUL_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_src1   (in_src1),
    .in_src2   (in_src2),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hi    (out_hi),
    .out_lo    (out_lo),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result of one operation.
  function automatic void ref_result(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MDU_MULT: begin
        q  = sa * sb;
        hi = q[63:32];
        lo = q[31:0];
      end
      MDU_MULTU: begin
        p  = 64'(a) * 64'(b);
        hi = p[63:32];
        lo = p[31:0];
      end
      MDU_DIV: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          q  = sa / sb;
          r  = sa % sb;
          hi = r[31:0];
          lo = q[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else begin
          hi = a % b;
          lo = a / b;
        end
      end
    endcase
  endfunction

  // Cycles from accept to the first out_valid cycle.
  function automatic int ref_latency(input logic [1:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
`ifdef MDU_DIV_EARLY_OUT_EN
    logic [31:0] ma, mb;
`endif
    if (op == MDU_MULT || op == MDU_MULTU) return MUL_LAT;
`ifdef MDU_DIV_EARLY_OUT_EN
    ma = (op == MDU_DIV && a[31]) ? -a : a;
    mb = (op == MDU_DIV && b[31]) ? -b : b;
    if (b == 0 || ma < mb) return 2;
`endif
    return XLEN + 2;
  endfunction

  // Transaction model state.
  bit          checking     = 1'b0;
  bit          m_busy       = 1'b0;
  bit          m_valid      = 1'b0;
  bit          m_reset_vals = 1'b1;
  int          m_remaining  = 0;
  logic [31:0] m_hi         = '0;
  logic [31:0] m_lo         = '0;

  always @(posedge clk) begin
    if (reset || flush) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
      if (reset) m_reset_vals = 1'b1;
    end else if (!m_busy) begin
      if (in_valid) begin
        ref_result(in_op, in_src1, in_src2, m_hi, m_lo);
        m_busy       = 1'b1;
        m_reset_vals = 1'b0;
        m_remaining  = ref_latency(in_op, in_src1, in_src2) - 1;
        if (m_remaining == 0) m_valid = 1'b1;
      end
    end else if (!m_valid) begin
      m_remaining--;
      if (m_remaining == 0) m_valid = 1'b1;
    end else if (out_ready) begin
      m_busy  = 1'b0;
      m_valid = 1'b0;
    end
  end

  // Compare process: handshake outputs every cycle, data whenever it is meaningful.
  always @(negedge clk) begin
    if (checking) begin
      check("in_ready", in_ready, !m_busy);
      check("busy", busy, m_busy);
      check("out_valid", out_valid, m_valid);
      if (m_valid) begin
        check("out_hi", out_hi, m_hi);
        check("out_lo", out_lo, m_lo);
      end else if (m_reset_vals) begin
        check("reset_hi", out_hi, 0);
        check("reset_lo", out_lo, 0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("issue_wait", in_ready, 1);
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    wait_ready();
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output int lat,
                        output logic [31:0] hi, output logic [31:0] lo);
    issue(op, a, b);
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("result_wait", out_valid, 1);
    hi = out_hi;
    lo = out_lo;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pin_model(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    logic [31:0] hi, lo;
    ref_result(op, a, b, hi, lo);
    check({name, "_hi"}, hi, ehi);
    check({name, "_lo"}, lo, elo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] hi, lo;
    bit          seen;

    reset     = 1'b1;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    in_op     = 2'd0;
    in_src1   = '0;
    in_src2   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    checking = 1'b1;

    // Hand-computed values that pin the reference model.
    pin_model("pin_mult",  MDU_MULT,  32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    pin_model("pin_multu", MDU_MULTU, 32'hFFFF_FFFF, 32'h2, 32'h0000_0001, 32'hFFFF_FFFE);
    pin_model("pin_div",   MDU_DIV,   32'hFFFF_FFF9, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    pin_model("pin_divu",  MDU_DIVU,  32'd100, 32'd7, 32'd2, 32'd14);
    pin_model("pin_dz",    MDU_DIVU,  32'h8000_0000, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF);
    pin_model("pin_ovf",   MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000);
    check("pin_lat_mul", ref_latency(MDU_MULT, 32'h1, 32'h1), 2);
    check("pin_lat_div", ref_latency(MDU_DIV, 32'hFFFF_FFF9, 32'h2), 34);

    // Directed operations from the test plan.
    run_op(MDU_MULT, 32'hFFFF_FFFF, 32'h2, 0, lat, hi, lo);
    check("mult_lat", lat, 2);
    check("mult_hi", hi, 32'hFFFF_FFFF);
    check("mult_lo", lo, 32'hFFFF_FFFE);
    run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'h2, 0, lat, hi, lo);
    check("multu_hi", hi, 32'h1);
    check("multu_lo", lo, 32'hFFFF_FFFE);
    run_op(MDU_DIV, 32'hFFFF_FFF9, 32'h2, 0, lat, hi, lo);
    check("div_lat", lat, 34);
    check("div_hi", hi, 32'hFFFF_FFFF);
    check("div_lo", lo, 32'hFFFF_FFFD);
    run_op(MDU_DIVU, 32'd100, 32'd7, 1, lat, hi, lo);
    check("divu_hi", hi, 2);
    check("divu_lo", lo, 14);
    run_op(MDU_DIVU, 32'h8000_0000, 32'h0, 0, lat, hi, lo);
    check("dz_hi", hi, 32'h8000_0000);
    check("dz_lo", lo, 32'hFFFF_FFFF);
    run_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, hi, lo);
    check("ovf_hi", hi, 0);
    check("ovf_lo", lo, 32'h8000_0000);
    run_op(MDU_DIVU, 32'd3, 32'd9, 0, lat, hi, lo);
`ifdef MDU_DIV_EARLY_OUT_EN
    check("early_lat", lat, 2);
`else
    check("early_lat", lat, 34);
`endif
    check("early_hi", hi, 3);
    check("early_lo", lo, 0);

    // Flush in cycle 10 of a divide.
    issue(MDU_DIV, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_ready", in_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("flush_no_valid", seen, 0);
    run_op(MDU_DIVU, 32'd100, 32'd7, 0, lat, hi, lo);
    check("after_flush_lo", lo, 14);
    check("after_flush_hi", hi, 2);

    // Backpressure: result held for 20 cycles (stability checked every cycle).
    run_op(MDU_MULT, 32'd12345, 32'hFFFF_FFFD, 20, lat, hi, lo);
    check("hold_ready_after", in_ready, 1);

    // Reset during MUL.
    issue(MDU_MULT, 32'd7, 32'd9);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_ready", in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_hi", out_hi, 0);
    check("rst_lo", out_lo, 0);

    // in_valid together with flush in IDLE: not accepted.
    wait_ready();
    in_valid = 1'b1;
    flush    = 1'b1;
    in_op    = MDU_MULT;
    in_src1  = 32'd5;
    in_src2  = 32'd6;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_accept_busy", busy, 0);
    @(negedge clk);
    check("flush_accept_busy2", busy, 0);

    // Randomised traffic with random backpressure and occasional flushes.
    for (int i = 0; i < 150; i++) begin
      logic [1:0]  op;
      logic [31:0] a, b, ehi, elo;
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      if ($urandom_range(0, 9) == 0) begin
        issue(op, a, b);
        repeat ($urandom_range(1, 40)) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
      end else begin
        run_op(op, a, b, $urandom_range(0, 3), lat, hi, lo);
        ref_result(op, a, b, ehi, elo);
        check("rand_hi", hi, ehi);
        check("rand_lo", lo, elo);
        check("rand_lat", lat, ref_latency(op, a, b));
      end
    end

    repeat (2) @(negedge clk);
    checking = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
